neocore_mini_core: RTL and testbench

- Small in-order 16-bit NeoCore execution core. Fetches 8-byte instruction windows from an external instruction memory and executes a subset of the NeoCore ISA: MOV immediate, ADD immediate, ADD register, NOP and HLT.
- Optionally issues two independent ALU instructions from one window in the same cycle.
- Sits between the fetch bus and the system memory model. The data port is present for bus compatibility but is idle in this subset.

---
 rtl/neocore_mini_core_if.sv | 29 ++
 rtl/neocore_mini_core.sv | 195 +++++++++++++++++++
 tb/tb_neocore_mini_core.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neocore_mini_core_if.sv
// Fetch and data bus bundle for neocore_mini_core.
// master = core side, slave = memory side.
interface neocore_mini_core_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [63:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [1:0]  dmem_size;
    logic        dmem_we;
    logic        dmem_req;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output imem_addr, imem_req,
        input  imem_rdata, imem_ack,
        output dmem_addr, dmem_wdata, dmem_size, dmem_we, dmem_req,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_addr, imem_req,
        output imem_rdata, imem_ack,
        input  dmem_addr, dmem_wdata, dmem_size, dmem_we, dmem_req,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/neocore_mini_core.sv
// neocore_mini_core: in-order 16-bit NeoCore subset (MOV/ADD/NOP/HLT) over 8-byte fetch windows.
// Define NEOCORE_DUAL_ISSUE_EN to retire two independent ALU ops from one window per cycle.
module neocore_mini_core_regfile #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [READ_PORTS-1:0][3:0]  raddr,
    output logic [READ_PORTS-1:0][15:0] rdata,
    input  logic                        we0,
    input  logic [3:0]                  waddr0,
    input  logic [15:0]                 wdata0,
    input  logic                        we1,
    input  logic [3:0]                  waddr1,
    input  logic [15:0]                 wdata1
);
    logic [15:0] registers [0:NUM_REGS-1];

    always_comb begin
        for (int unsigned i = 0; i < READ_PORTS; i++)
            rdata[i] = (32'(raddr[i]) < NUM_REGS) ? registers[raddr[i]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            registers <= '{default: '0};
        end else begin
            if (we0 && 32'(waddr0) < NUM_REGS) registers[waddr0] <= wdata0;
            if (we1 && 32'(waddr1) < NUM_REGS) registers[waddr1] <= wdata1;
        end
    end
endmodule

module neocore_mini_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    neocore_mini_core_if.master        bus,
    output logic                       halted,
    output logic [31:0]                current_pc,
    output logic                       dual_issue_active
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    typedef enum logic [2:0] {OP_NOP, OP_MOVI, OP_ADDI, OP_ADDR, OP_HLT} op_t;
    typedef struct packed {
        op_t         op;
        logic [2:0]  len;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [15:0] imm;
    } insn_t;

`ifdef NEOCORE_DUAL_ISSUE_EN
    localparam int unsigned READ_PORTS = 4;
`else
    localparam int unsigned READ_PORTS = 2;
`endif

    // Bytes past the end of the window read as zero so a trailing decode never wraps.
    function automatic logic [7:0] byte_at(input logic [63:0] win, input logic [3:0] idx);
        logic [63:0] sh;
        sh = win << {idx[2:0], 3'b000};
        return idx[3] ? 8'h00 : sh[63:56];
    endfunction

    function automatic insn_t decode(input logic [63:0] win, input logic [3:0] off);
        insn_t      d;
        logic [7:0] b2, b3, b4;
        b2    = byte_at(win, off + 4'd2);
        b3    = byte_at(win, off + 4'd3);
        b4    = byte_at(win, off + 4'd4);
        d.rd  = b2[3:0];
        d.rn  = b3[3:0];
        d.imm = {b3, b4};
        case ({byte_at(win, off), byte_at(win, off + 4'd1)})
            16'h0009: begin d.op = OP_MOVI; d.len = 3'd5; end
            16'h0001: begin d.op = OP_ADDI; d.len = 3'd5; end
            16'h0101: begin d.op = OP_ADDR; d.len = 3'd4; end
            16'h0000: begin d.op = OP_NOP;  d.len = 3'd2; end
            default:  begin d.op = OP_HLT;  d.len = 3'd2; end
        endcase
        return d;
    endfunction

    state_t                         state;
    logic [31:0]                    pc;
    logic                           req;
    logic [63:0]                    ibuf;
    insn_t                          i0;
    logic                           alu0;
    logic                           we0;
    logic                           we1;
    logic                           dual;
    logic [3:0]                     step;
    logic [3:0]                     waddr1;
    logic [15:0]                    res0;
    logic [15:0]                    res1;
    logic [READ_PORTS-1:0][3:0]     raddr;
    logic [READ_PORTS-1:0][15:0]    rdata;
    logic                           unused_dmem;

    assign i0   = decode(ibuf, 4'd0);
    assign alu0 = i0.op inside {OP_MOVI, OP_ADDI, OP_ADDR};
    assign res0 = (i0.op == OP_MOVI) ? i0.imm
                                     : rdata[0] + ((i0.op == OP_ADDR) ? rdata[1] : i0.imm);

`ifdef NEOCORE_DUAL_ISSUE_EN
    insn_t i1;
    logic  alu1;
    assign i1     = decode(ibuf, {1'b0, i0.len});
    assign alu1   = i1.op inside {OP_MOVI, OP_ADDI, OP_ADDR};
    assign raddr  = {i1.rn, i1.rd, i0.rn, i0.rd};
    assign res1   = (i1.op == OP_MOVI) ? i1.imm
                                       : rdata[2] + ((i1.op == OP_ADDR) ? rdata[3] : i1.imm);
    // Both ops read pre-edge values; independence from the first rd keeps that equal to serial order.
    assign dual   = alu0 && alu1 && ({1'b0, i0.len} + {1'b0, i1.len} <= 4'd8) &&
                    (i1.rd != i0.rd) && !(i1.op == OP_ADDR && i1.rn == i0.rd);
    assign step   = dual ? {1'b0, i0.len} + {1'b0, i1.len} : {1'b0, i0.len};
    assign waddr1 = i1.rd;
`else
    assign raddr  = {i0.rn, i0.rd};
    assign res1   = '0;
    assign dual   = 1'b0;
    assign step   = {1'b0, i0.len};
    assign waddr1 = '0;
`endif

    assign we0 = (state == EXEC) && alu0;
    assign we1 = (state == EXEC) && dual;

    neocore_mini_core_regfile #(
        .NUM_REGS   (NUM_REGS),
        .READ_PORTS (READ_PORTS)
    ) regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr  (raddr),
        .rdata  (rdata),
        .we0    (we0),
        .waddr0 (i0.rd),
        .wdata0 (res0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (res1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            req               <= 1'b0;
            ibuf              <= '0;
            halted            <= 1'b0;
            dual_issue_active <= 1'b0;
        end else begin
            dual_issue_active <= 1'b0;
            case (state)
                FETCH: begin
                    if (req && bus.imem_ack) begin
                        ibuf  <= bus.imem_rdata;
                        req   <= 1'b0;
                        state <= EXEC;
                    end else begin
                        req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (i0.op == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        pc                <= pc + 32'(step);
                        dual_issue_active <= dual;
                        state             <= FETCH;
                    end
                end
                HALT: ;
                default: state <= HALT;
            endcase
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.imem_req   = req;
    assign bus.dmem_addr  = '0;
    assign bus.dmem_wdata = '0;
    assign bus.dmem_size  = '0;
    assign bus.dmem_we    = 1'b0;
    assign bus.dmem_req   = 1'b0;
    assign current_pc     = pc;
    assign unused_dmem    = ^{bus.dmem_rdata, bus.dmem_ack};
endmodule

// File: tb/tb_neocore_mini_core.sv
// Scoreboard bench for neocore_mini_core: a program-level reference model predicts fetch
// addresses and final architectural state; monitors compare as the core fetches and halts.
`timescale 1ns/1ps
module tb_neocore_mini_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halted;
    logic [31:0] current_pc;
    logic        dual_issue_active;

    neocore_mini_core_if bus();

    neocore_mini_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .halted            (halted),
        .current_pc        (current_pc),
        .dual_issue_active (dual_issue_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][15:0] regs;
        logic [31:0]       pc;
        logic [31:0]       duals;
    } exp_t;

    localparam int K_NOP = 0, K_MOV = 1, K_ADDI = 2, K_ADDR = 3, K_HLT = 4;

    exp_t        exp_q[$];
    logic [31:0] fetch_q[$];
    logic [7:0]  mem [0:255];
    logic [7:0]  prog[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned dual_seen = 0;
    bit          stall_mode = 0;
    bit          spurious_en = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    // ---------------- program building ----------------
    function automatic logic [7:0] reg_byte(input int unsigned r);
        logic [3:0] hi;
        hi = 4'($urandom_range(0, 15));
        return {hi, 4'(r)};
    endfunction

    task automatic e_mov(input int unsigned rd, input logic [15:0] imm);
        prog.push_back(8'h00); prog.push_back(8'h09); prog.push_back(reg_byte(rd));
        prog.push_back(imm[15:8]); prog.push_back(imm[7:0]);
    endtask
    task automatic e_addi(input int unsigned rd, input logic [15:0] imm);
        prog.push_back(8'h00); prog.push_back(8'h01); prog.push_back(reg_byte(rd));
        prog.push_back(imm[15:8]); prog.push_back(imm[7:0]);
    endtask
    task automatic e_addr(input int unsigned rd, input int unsigned rn);
        prog.push_back(8'h01); prog.push_back(8'h01);
        prog.push_back(reg_byte(rd)); prog.push_back(reg_byte(rn));
    endtask
    task automatic e_nop();
        prog.push_back(8'h00); prog.push_back(8'h00);
    endtask
    task automatic e_hlt();
        prog.push_back(8'h00); prog.push_back(8'h12);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        prog.delete();
    endtask

    function automatic logic [63:0] window(input logic [31:0] a);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[55:0], mem[8'(a + 32'(i))]};
        return w;
    endfunction

    // ---------------- reference model ----------------
    task automatic mdecode(input int unsigned a, output int k, output int unsigned len,
                           output int unsigned rd, output int unsigned rn, output int unsigned imm);
        logic [7:0] s, o, b2, b3, b4;
        s  = mem[8'(a)];     o  = mem[8'(a + 1)];
        b2 = mem[8'(a + 2)]; b3 = mem[8'(a + 3)]; b4 = mem[8'(a + 4)];
        rd = int'(b2[3:0]); rn = int'(b3[3:0]); imm = b3 * 256 + b4;
        if (s == 8'h00 && o == 8'h09)      begin k = K_MOV;  len = 5; end
        else if (s == 8'h00 && o == 8'h01) begin k = K_ADDI; len = 5; end
        else if (s == 8'h01 && o == 8'h01) begin k = K_ADDR; len = 4; end
        else if (s == 8'h00 && o == 8'h00) begin k = K_NOP;  len = 2; end
        else                               begin k = K_HLT;  len = 2; end
    endtask

    function automatic int unsigned apply(input int k, input int unsigned a, input int unsigned b,
                                          input int unsigned imm);
        if (k == K_MOV) return imm;
        if (k == K_ADDI) return (a + imm) % 65536;
        return (a + b) % 65536;
    endfunction

    task automatic push_expect();
        int unsigned r [16];
        int unsigned pc, duals, l0, d0, n0, m0, l1, d1, n1, m1, v0, v1;
        int k0, k1;
        bit dual;
        exp_t e;
        foreach (r[i]) r[i] = 0;
        pc = 0; duals = 0;
        for (int g = 0; g < 200; g++) begin
            fetch_q.push_back(pc);
            mdecode(pc, k0, l0, d0, n0, m0);
            if (k0 == K_HLT) break;
            dual = 0; k1 = K_HLT; l1 = 0; d1 = 0; n1 = 0; m1 = 0;
`ifdef NEOCORE_DUAL_ISSUE_EN
            if (k0 != K_NOP) begin
                mdecode(pc + l0, k1, l1, d1, n1, m1);
                if (k1 != K_NOP && k1 != K_HLT && l0 + l1 <= 8 && d1 != d0 &&
                    !(k1 == K_ADDR && n1 == d0)) dual = 1;
            end
`endif
            v0 = apply(k0, r[d0], r[n0], m0);
            v1 = apply(k1, r[d1], r[n1], m1);
            if (k0 != K_NOP) r[d0] = v0;
            if (dual) begin r[d1] = v1; duals++; pc += l1; end
            pc += l0;
        end
        for (int i = 0; i < 16; i++) e.regs[i] = 16'(r[i]);
        e.pc = pc; e.duals = duals;
        exp_q.push_back(e);
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        logic [31:0] a;
        int unsigned d;
        bit ok, aborted;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.imem_ack = 1'b0;
            if (!rst && bus.imem_req) begin
                a = bus.imem_addr; ok = 1; aborted = 0;
                d = stall_mode ? 5 : $urandom_range(0, 2);
                for (int k = 0; k < d; k++) begin
                    @(posedge clk); #1;
                    if (rst) begin aborted = 1; break; end
                    if (!bus.imem_req || bus.imem_addr != a) ok = 0;
                end
                if (!aborted) begin
                    if (d > 0) check("fetch_hold_stable", 32'(ok), 32'd1);
                    bus.imem_rdata = window(a);
                    bus.imem_ack   = 1'b1;
                end
            end else if (!rst && spurious_en && $urandom_range(0, 3) == 0) begin
                bus.imem_rdata = '1;
                bus.imem_ack   = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0; dual_seen = 0;
            end else begin
                if (dual_issue_active) dual_seen++;
                if (bus.imem_req && bus.imem_ack) begin
                    if (fetch_q.size() == 0) check("fetch_unexpected", bus.imem_addr, 32'hFFFF_FFFF);
                    else check("fetch_addr", bus.imem_addr, fetch_q.pop_front());
                end
                if (halted && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("halt_unexpected", 32'(halted), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 16; i++)
                            check($sformatf("r%0d", i), 32'(dut.regfile.registers[i]), 32'(e.regs[i]));
                        check("halt_pc", current_pc, e.pc);
                        check("dual_pulses", dual_seen, e.duals);
                        check("fetch_left", fetch_q.size(), 0);
                    end
                end
                prev = halted;
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        fetch_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++)
            check($sformatf("reset_r%0d", i), 32'(dut.regfile.registers[i]), 32'd0);
        check("reset_pc", current_pc, 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_req", 32'(bus.imem_req), 32'd0);
        check("reset_dual", 32'(dual_issue_active), 32'd0);
        check("reset_dmem", {bus.dmem_addr | bus.dmem_wdata} |
              32'({bus.dmem_size, bus.dmem_we, bus.dmem_req}), 32'd0);
    endtask

    task automatic wait_halt();
        int unsigned n;
        n = 0;
        while (!halted && n < 1000) begin @(posedge clk); n++; end
        #2;
        check("halt_within_budget", 32'(halted), 32'd1);
        if (!halted) begin fetch_q.delete(); exp_q.delete(); end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic run_loaded();
        do_reset();
        push_expect();
        wait_halt();
    endtask

    task automatic build_t1();
        e_mov(1, 16'd5); e_mov(2, 16'd7); e_addr(1, 2); e_hlt(); load_prog();
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        int unsigned n, kind, start_pc;

        build_t1(); run_loaded();
        check("t1_r1", 32'(dut.regfile.registers[1]), 32'h000C);
        check("t1_r2", 32'(dut.regfile.registers[2]), 32'h0007);
        check("t1_pc", current_pc, 32'd14);
        start_pc = current_pc;
        repeat (10) @(posedge clk);
        #2;
        check("halt_frozen_pc", current_pc, start_pc);
        check("halt_no_req", 32'(bus.imem_req), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);

        e_mov(3, 16'd10); e_mov(4, 16'd20); e_addr(3, 4); e_hlt(); load_prog(); run_loaded();
        check("t2_r3", 32'(dut.regfile.registers[3]), 32'h001E);
        check("t2_r4", 32'(dut.regfile.registers[4]), 32'h0014);

        e_mov(5, 16'd3); e_addi(5, 16'd2); e_addi(5, 16'd1); e_hlt(); load_prog(); run_loaded();
        check("t3_r5", 32'(dut.regfile.registers[5]), 32'h0006);
        check("t3_pc", current_pc, 32'd15);

        e_mov(6, 16'hFFFF); e_addi(6, 16'd2); e_hlt(); load_prog(); run_loaded();
        check("wrap_r6", 32'(dut.regfile.registers[6]), 32'h0001);

        e_mov(1, 16'd1); e_mov(2, 16'd2); e_mov(3, 16'd3); e_mov(4, 16'd4);
        e_addr(1, 2); e_addr(3, 4); e_hlt(); load_prog(); run_loaded();
        check("indep_r1", 32'(dut.regfile.registers[1]), 32'd3);
        check("indep_r3", 32'(dut.regfile.registers[3]), 32'd7);

        e_mov(1, 16'd1); e_mov(2, 16'd2); e_mov(3, 16'd3); e_mov(4, 16'd4);
        e_addr(1, 2); e_addr(2, 1); e_hlt(); load_prog(); run_loaded();
        check("dep_r1", 32'(dut.regfile.registers[1]), 32'd3);
        check("dep_r2", 32'(dut.regfile.registers[2]), 32'd5);
        check("dep_pulses", dual_seen, 32'd0);

        stall_mode = 1;
        build_t1(); run_loaded();
        stall_mode = 0;

        // Reset mid-run, then the same program must run to completion from scratch.
        e_mov(5, 16'd3); e_addi(5, 16'd2); e_addi(5, 16'd1); e_mov(7, 16'h1234);
        e_addr(7, 5); e_hlt(); load_prog();
        do_reset(); push_expect();
        repeat (8) @(posedge clk);
        check("midrun_not_halted", 32'(halted), 32'd0);
        do_reset(); push_expect(); wait_halt();
        check("midrun_r7", 32'(dut.regfile.registers[7]), 32'h123A);

        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(3, 25);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0: e_mov($urandom_range(0, 15), 16'($urandom));
                    1: e_addi($urandom_range(0, 15), 16'($urandom));
                    2: e_addr($urandom_range(0, 15), $urandom_range(0, 15));
                    default: e_nop();
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                prog.push_back(8'h02); prog.push_back(8'h01);
            end else begin
                e_hlt();
            end
            load_prog(); run_loaded();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
